// File: rtl/keyboard_board_game_ctrl_pkg.sv
// Shared symbol codes, PS/2 scancodes and controller state encoding for the
// keyboard-driven NxN board game.
package keyboard_board_game_ctrl_pkg;

  localparam logic [1:0] SYM_EMPTY = 2'b00;
  localparam logic [1:0] SYM_X     = 2'b01;
  localparam logic [1:0] SYM_O     = 2'b10;

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_R     = 8'h2D;
  localparam logic [7:0] KEY_ENTER = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EVAL   = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

  function automatic logic [1:0] sym_for_turn(input logic turn);
    return turn ? SYM_O : SYM_X;
  endfunction

endpackage

// File: rtl/keyboard_board_game_ctrl_win_check.sv
// Combinational line scan: reports a win when any row, column or diagonal
// holds N_DIM identical non-empty symbols.
module board_win_check
  import keyboard_board_game_ctrl_pkg::*;
#(
  parameter int N_DIM = 3
) (
  input  logic [0:2*N_DIM*N_DIM-1] sym_vec_i,
  output logic                     win_o,
  output logic [1:0]               winner_o
);

  localparam int VEC_W = 2*N_DIM*N_DIM;
  localparam int IDX_W = $clog2(VEC_W);

  // Returns the common symbol of a line, or EMPTY as soon as any cell differs.
  function automatic logic [1:0] line_sym(input logic [0:VEC_W-1] v,
                                          input int r0, input int c0,
                                          input int dr, input int dc);
    logic [1:0] s;
    s = v[IDX_W'(2*(c0 + N_DIM*r0)) +: 2];
    for (int i = 1; i < N_DIM; i++) begin
      if (v[IDX_W'(2*((c0 + i*dc) + N_DIM*(r0 + i*dr))) +: 2] != s) s = SYM_EMPTY;
    end
    return s;
  endfunction

  always_comb begin
    win_o    = 1'b0;
    winner_o = SYM_EMPTY;
    for (int i = 0; i < N_DIM; i++) begin
      if (!win_o && line_sym(sym_vec_i, i, 0, 0, 1) != SYM_EMPTY) begin
        win_o    = 1'b1;
        winner_o = line_sym(sym_vec_i, i, 0, 0, 1);
      end
      if (!win_o && line_sym(sym_vec_i, 0, i, 1, 0) != SYM_EMPTY) begin
        win_o    = 1'b1;
        winner_o = line_sym(sym_vec_i, 0, i, 1, 0);
      end
    end
    if (!win_o && line_sym(sym_vec_i, 0, 0, 1, 1) != SYM_EMPTY) begin
      win_o    = 1'b1;
      winner_o = line_sym(sym_vec_i, 0, 0, 1, 1);
    end
    if (!win_o && line_sym(sym_vec_i, 0, N_DIM-1, 1, -1) != SYM_EMPTY) begin
      win_o    = 1'b1;
      winner_o = line_sym(sym_vec_i, 0, N_DIM-1, 1, -1);
    end
  end

endmodule

// File: rtl/keyboard_board_game_ctrl.sv
// Keyboard-driven NxN X/O board controller: synchronises the receiver strobe,
// decodes one scancode per handshake and tracks board, turn, win and draw.
module keyboard_board_game_ctrl
  import keyboard_board_game_ctrl_pkg::*;
#(
  parameter int N_DIM       = 3,
  parameter bit CURSOR_WRAP = 1'b1,
  parameter int POS_W       = 3,
  parameter int CNT_W       = 7
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [7:0]               iData,
  input  logic                     iKeyboardFlag,
  output logic                     oKeyboardReset,
  output logic [POS_W-1:0]         oCurrentPosX,
  output logic [POS_W-1:0]         oCurrentPosY,
  output logic [0:2*N_DIM*N_DIM-1] oSymVector,
  output logic                     oTurn,
  output logic [CNT_W-1:0]         oMoveCount,
  output logic                     oWinFlag,
  output logic [1:0]               oWinner,
  output logic                     oDrawFlag
);

  localparam int                VEC_W    = 2*N_DIM*N_DIM;
  localparam int                IDX_W    = $clog2(VEC_W);
  localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(N_DIM-1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(N_DIM*N_DIM);

  logic [2:0]       sync_q;
  logic             fall_w;
  logic             pending_q;
  state_e           state_q;
  logic [7:0]       key_q;
  logic [0:VEC_W-1] sym_q;
  logic [POS_W-1:0] pos_x_q, pos_y_q, pos_x_d, pos_y_d;
  logic             turn_q, win_q, draw_q, ack_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       winner_q;
  logic [IDX_W-1:0] cur_idx;
  logic [1:0]       cur_cell;
  logic             win_w;
  logic [1:0]       winner_w;

  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p, input logic up);
    if (up) begin
      if (p == POS_MAX) return CURSOR_WRAP ? '0 : p;
      return p + POS_W'(1);
    end
    if (p == '0) return CURSOR_WRAP ? POS_MAX : p;
    return p - POS_W'(1);
  endfunction

  // sync_q[1] is the synchronised strobe, sync_q[2] its previous value.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], iKeyboardFlag};
  end

  assign fall_w   = sync_q[2] & ~sync_q[1];
  assign cur_idx  = IDX_W'(2*(int'(pos_x_q) + N_DIM*int'(pos_y_q)));
  assign cur_cell = sym_q[cur_idx +: 2];

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    case (key_q)
      KEY_D:   pos_x_d = step_pos(pos_x_q, 1'b1);
      KEY_A:   pos_x_d = step_pos(pos_x_q, 1'b0);
      KEY_S:   pos_y_d = step_pos(pos_y_q, 1'b1);
      KEY_W:   pos_y_d = step_pos(pos_y_q, 1'b0);
      default: ;
    endcase
  end

  board_win_check #(.N_DIM(N_DIM)) u_win_check (
    .sym_vec_i (sym_q),
    .win_o     (win_w),
    .winner_o  (winner_w)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      key_q     <= '0;
      sym_q     <= '0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      turn_q    <= 1'b0;
      cnt_q     <= '0;
      win_q     <= 1'b0;
      winner_q  <= SYM_EMPTY;
      draw_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (fall_w) pending_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          // An edge landing in the same cycle as the hand-off is dropped.
          if (pending_q) begin
            key_q     <= iData;
            pending_q <= 1'b0;
            state_q   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          pos_x_q <= pos_x_d;
          pos_y_q <= pos_y_d;
          if (key_q == KEY_ENTER && !win_q && !draw_q && cur_cell == SYM_EMPTY) begin
            sym_q[cur_idx +: 2] <= sym_for_turn(turn_q);
            turn_q              <= ~turn_q;
            cnt_q               <= cnt_q + CNT_W'(1);
          end else if (key_q == KEY_R) begin
            sym_q    <= '0;
            turn_q   <= 1'b0;
            cnt_q    <= '0;
            win_q    <= 1'b0;
            winner_q <= SYM_EMPTY;
            draw_q   <= 1'b0;
          end
          state_q <= ST_EVAL;
        end
        ST_EVAL: begin
          if (win_w && !win_q) begin
            win_q    <= 1'b1;
            winner_q <= winner_w;
          end
          if (cnt_q == CNT_FULL && !win_w) draw_q <= 1'b1;
          ack_q   <= 1'b1;
          state_q <= ST_ACK;
        end
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign oKeyboardReset = ack_q;
  assign oCurrentPosX   = pos_x_q;
  assign oCurrentPosY   = pos_y_q;
  assign oSymVector     = sym_q;
  assign oTurn          = turn_q;
  assign oMoveCount     = cnt_q;
  assign oWinFlag       = win_q;
  assign oWinner        = winner_q;
  assign oDrawFlag      = draw_q;

endmodule
